// File: rtl/cpu_controller_pkg.sv
// Shared types and constants for the instruction controller.
// Contents: FSM state enum, opcode/op field values, ALU operation encodings,
// and the sign-extension helper for the 8-bit immediate.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_ALU,
        S_WREG,
        S_WIMM
    } state_e;

    // Instruction class in IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Sub-operation in IR[12:11]; meaning depends on the opcode
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;

    // ALU operation codes driven on ALUop
    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_AND  = 2'b10,
        ALUOP_NOTB = 2'b11
    } alu_op_e;

    function automatic logic [15:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Control bundle between host, controller and datapath.
// Host side: s, load, in (to controller); w, err (from controller).
// Datapath side: register enables, selects, indices, shift, ALUop, datapath_in.
interface cpu_controller_if;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic        err;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] datapath_in;

    // Controller view: consumes host commands, drives every datapath control.
    modport master (
        input  s, load, in,
        output w, err, vsel, loada, loadb, loadc, loads, write,
        output asel, bsel, readnum, writenum, shift, ALUop, datapath_in
    );

    // Host/datapath view.
    modport slave (
        output s, load, in,
        input  w, err, vsel, loada, loadb, loadc, loads, write,
        input  asel, bsel, readnum, writenum, shift, ALUop, datapath_in
    );
endinterface

// File: rtl/cpu_controller_decoder.sv
// Combinational field extraction from the instruction register.
// Ports: ir_i (16-bit IR) -> opcode, op, register indices, shift, sximm8,
// and an illegal flag for encodings outside the supported instruction set.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  opcode_o,
    output logic [1:0]  op_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [1:0]  shift_o,
    output logic [15:0] sximm8_o,
    output logic        illegal_o
);

    assign opcode_o = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign shift_o  = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = sext8(ir_i[7:0]);

    // Every op of the ALU class is legal; MOV only has the imm and reg forms.
    always_comb begin
        illegal_o = 1'b1;
        if (opcode_o == OPC_ALU)
            illegal_o = 1'b0;
        else if (opcode_o == OPC_MOV && (op_o == OP_MOVI || op_o == OP_MOVR))
            illegal_o = 1'b0;
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register + sequencing FSM driving the register-file/ALU datapath.
// Ports: clk, reset (async, active-high); bus (master modport): s/load/in from
// the host, w/err status, and all datapath control outputs (Moore-decoded).
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    cpu_controller_if.master  bus
);

    state_e      state_q;
    logic [15:0] ir_q;
    logic        err_q;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic        illegal;

    instr_decoder u_dec (
        .ir_i      (ir_q),
        .opcode_o  (opcode),
        .op_o      (op),
        .rn_o      (rn),
        .rd_o      (rd),
        .rm_o      (rm),
        .shift_o   (shift),
        .sximm8_o  (sximm8),
        .illegal_o (illegal)
    );

    logic is_movi, is_movr, is_mvn, is_cmp;
    assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
    assign is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
    assign is_mvn  = (opcode == OPC_ALU) && (op == OP_MVN);
    assign is_cmp  = (opcode == OPC_ALU) && (op == OP_CMP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            // IR is only writable while idle; a simultaneous s sees the new
            // word because DECODE evaluates IR one cycle later.
            if (state_q == S_WAIT && bus.load)
                ir_q <= bus.in;

            case (state_q)
                S_WAIT: begin
                    if (bus.s) begin
                        state_q <= S_DECODE;
                        err_q   <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        state_q <= S_WAIT;
                        err_q   <= 1'b1;
                    end else if (is_movi) begin
                        state_q <= S_WIMM;
                    end else if (is_movr || is_mvn) begin
                        // Single-operand forms skip the A read.
                        state_q <= S_GETB;
                    end else begin
                        state_q <= S_GETA;
                    end
                end
                S_GETA:  state_q <= S_GETB;
                S_GETB:  state_q <= S_ALU;
                S_ALU:   state_q <= is_cmp ? S_WAIT : S_WREG;
                S_WREG:  state_q <= S_WAIT;
                S_WIMM:  state_q <= S_WAIT;
                default: state_q <= S_WAIT;
            endcase
        end
    end

    always_comb begin
        bus.w           = (state_q == S_WAIT);
        bus.err         = err_q;
        bus.vsel        = 1'b0;
        bus.loada       = 1'b0;
        bus.loadb       = 1'b0;
        bus.loadc       = 1'b0;
        bus.loads       = 1'b0;
        bus.write       = 1'b0;
        bus.asel        = 1'b0;
        bus.bsel        = 1'b0;
        bus.readnum     = 3'd0;
        bus.writenum    = 3'd0;
        bus.shift       = 2'd0;
        bus.ALUop       = 2'd0;
        bus.datapath_in = sximm8;

        case (state_q)
            S_GETA: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            S_GETB: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                bus.shift   = shift;
            end
            S_ALU: begin
                // Shift stays valid so the shifted B reaches the ALU this cycle.
                bus.shift = shift;
                bus.asel  = is_movr || is_mvn;
                // MOV reg is computed as 0 + shifted B.
                bus.ALUop = is_movr ? ALUOP_ADD : op;
                if (is_cmp)
                    bus.loads = 1'b1;
                else
                    bus.loadc = 1'b1;
            end
            S_WREG: begin
                bus.write    = 1'b1;
                bus.writenum = rd;
                bus.vsel     = 1'b0;
            end
            S_WIMM: begin
                bus.write    = 1'b1;
                bus.writenum = rn;
                bus.vsel     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: hand-computed expectations per cycle.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_cpu_controller;

    localparam logic [4:0] EN_0 = 5'b00000;
    localparam logic [4:0] EN_A = 5'b10000;
    localparam logic [4:0] EN_B = 5'b01000;
    localparam logic [4:0] EN_C = 5'b00100;
    localparam logic [4:0] EN_S = 5'b00010;
    localparam logic [4:0] EN_W = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_tot  = 0;
    logic seen;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] en();
        return {11'd0, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a word while idle, then start it; returns in DECODE.
    task automatic issue(input logic [15:0] word);
        bus.load = 1'b1;
        bus.in   = word;
        tick();
        bus.load = 1'b0;
        bus.s    = 1'b1;
        tick();
        bus.s    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        bus.s    = 1'b0;
        bus.load = 1'b0;
        bus.in   = 16'h0000;
        repeat (2) tick();

        // Reset state
        chk("rst_w",       bus.w, 1);
        chk("rst_err",     bus.err, 0);
        chk("rst_en",      en(), EN_0);
        chk("rst_readnum", bus.readnum, 0);
        chk("rst_writenum",bus.writenum, 0);
        chk("rst_shift",   bus.shift, 0);
        chk("rst_aluop",   bus.ALUop, 0);
        chk("rst_dpin",    bus.datapath_in, 0);
        chk("rst_sel",     {bus.vsel, bus.asel, bus.bsel}, 0);
        reset = 1'b0;

        // Reset mid-GETA
        issue(16'hA148);
        chk("ra_decode_w", bus.w, 0);
        tick();
        chk("ra_geta_en", en(), EN_A);
        chk("ra_geta_rn", bus.readnum, 1);
        reset = 1'b1;
        #1;
        chk("ra_async_w",  bus.w, 1);
        chk("ra_async_en", en(), EN_0);
        chk("ra_async_err",bus.err, 0);
        #2 reset = 1'b0;
        tick();
        chk("ra_after_w",  bus.w, 1);
        chk("ra_after_en", en(), EN_0);

        // MOV R5,#-2
        issue(16'hD5FE);
        chk("movi_dec_en", en(), EN_0);
        tick();
        chk("movi_en",       en(), EN_W);
        chk("movi_writenum", bus.writenum, 5);
        chk("movi_vsel",     bus.vsel, 1);
        chk("movi_dpin",     bus.datapath_in, 16'hFFFE);
        chk("movi_busy",     bus.w, 0);
        tick();
        chk("movi_lat3",     bus.w, 1);

        // ADD R2,R1,R0 LSL#1
        issue(16'hA148);
        tick();
        chk("add_geta_en", en(), EN_A);
        chk("add_geta_rn", bus.readnum, 1);
        tick();
        chk("add_getb_en", en(), EN_B);
        chk("add_getb_rm", bus.readnum, 0);
        chk("add_shift",   bus.shift, 2'b01);
        tick();
        chk("add_alu_en",  en(), EN_C);
        chk("add_aluop",   bus.ALUop, 2'b00);
        chk("add_asel",    bus.asel, 0);
        tick();
        chk("add_wreg_en", en(), EN_W);
        chk("add_wreg_rd", bus.writenum, 2);
        chk("add_vsel",    bus.vsel, 0);
        chk("add_busy",    bus.w, 0);
        tick();
        chk("add_lat6",    bus.w, 1);

        // CMP R1,R0
        issue(16'hA900);
        seen = bus.loadc | bus.write;
        tick();
        seen = seen | bus.loadc | bus.write;
        tick();
        seen = seen | bus.loadc | bus.write;
        tick();
        chk("cmp_alu_en", en(), EN_S);
        chk("cmp_aluop",  bus.ALUop, 2'b01);
        chk("cmp_busy",   bus.w, 0);
        seen = seen | bus.loadc | bus.write;
        tick();
        chk("cmp_lat5",   bus.w, 1);
        chk("cmp_no_wr",  seen, 0);

        // MOV R4,R2
        issue(16'hC082);
        tick();
        chk("movr_getb_en", en(), EN_B);
        chk("movr_getb_rm", bus.readnum, 2);
        tick();
        chk("movr_alu_en",  en(), EN_C);
        chk("movr_asel",    bus.asel, 1);
        chk("movr_aluop",   bus.ALUop, 2'b00);
        tick();
        chk("movr_wreg_rd", bus.writenum, 4);
        tick();
        chk("movr_lat5",    bus.w, 1);

        // MVN R3,R0 loaded and started on the same edge
        bus.load = 1'b1;
        bus.in   = 16'hB860;
        bus.s    = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.s    = 1'b0;
        chk("mvn_dec_w",    bus.w, 0);
        tick();
        chk("mvn_getb_en",  en(), EN_B);
        chk("mvn_getb_rm",  bus.readnum, 0);
        tick();
        chk("mvn_asel",     bus.asel, 1);
        chk("mvn_aluop",    bus.ALUop, 2'b11);
        tick();
        chk("mvn_wreg_en",  en(), EN_W);
        chk("mvn_wreg_rd",  bus.writenum, 3);
        tick();
        chk("mvn_lat5",     bus.w, 1);

        // Illegal instruction
        issue(16'hE000);
        chk("ill_dec_en",  en(), EN_0);
        tick();
        chk("ill_lat2",    bus.w, 1);
        chk("ill_err",     bus.err, 1);
        chk("ill_en",      en(), EN_0);
        tick();
        chk("ill_sticky",  bus.err, 1);

        // Legal ADD clears err; busy load/s pulses are ignored
        issue(16'hA148);
        chk("clr_err",     bus.err, 0);
        tick();
        bus.load = 1'b1;
        bus.in   = 16'hE000;
        bus.s    = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.s    = 1'b0;
        chk("busy_getb_en", en(), EN_B);
        chk("busy_getb_rm", bus.readnum, 0);
        tick();
        chk("busy_alu_en",  en(), EN_C);
        tick();
        chk("busy_wreg_rd", bus.writenum, 2);
        tick();
        chk("busy_done_w",  bus.w, 1);
        chk("busy_err",     bus.err, 0);

        // s held high: IR still ADD, instructions restart back to back
        bus.s = 1'b1;
        tick();
        tick();
        chk("hold_geta_en", en(), EN_A);
        chk("hold_ir_rn",   bus.readnum, 1);
        repeat (4) tick();
        chk("hold_wait_w",  bus.w, 1);
        tick();
        chk("hold_restart", bus.w, 0);
        bus.s = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
